// File: rtl/vga_collision.sv
// Per-frame sprite collision accumulator with an Avalon-MM register window.
// Overlaps are gathered as sticky bits during a frame and published at line 480.
module vga_collision #(
    parameter int MAX_BULLETS       = 5,
    parameter int MAX_ENEMY_BULLETS = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pixel_valid,
    input  logic [9:0]                   vcount,
    input  logic                         ship_on,
    input  logic [1:0]                   enemy_on,
    input  logic [MAX_BULLETS-1:0]       bullet_on,
    input  logic [MAX_ENEMY_BULLETS-1:0] enemy_bullet_on,
    input  logic                         chipselect,
    input  logic                         read,
    input  logic                         write,
    input  logic [2:0]                   address,
    input  logic [7:0]                   writedata,
    output logic [7:0]                   readdata,
    output logic                         irq
);

    typedef enum logic [2:0] {
        REG_STAT0  = 3'd0,
        REG_STAT1  = 3'd1,
        REG_FRAMES = 3'd2,
        REG_HITS   = 3'd3,
        REG_CTRL   = 3'd4,
        REG_CLEAR  = 3'd5,
        REG_HITCLR = 3'd6
    } reg_addr_t;

    localparam int EB_W = (MAX_ENEMY_BULLETS < 6) ? MAX_ENEMY_BULLETS : 6;
    localparam int B_W  = (MAX_BULLETS < 5) ? MAX_BULLETS : 5;

    logic [9:0]                   vcount_q;
    logic                         acc_se, stat_se, nxt_se;
    logic [MAX_ENEMY_BULLETS-1:0] acc_eb, stat_eb, nxt_eb;
    logic [MAX_BULLETS-1:0]       acc_b, stat_b, nxt_b;
    logic [1:0]                   acc_e, stat_e, nxt_e;
    logic [7:0]                   frame_count, ship_hits;
    logic                         irq_pending, irq_en, enable;

    logic       frame_end, sample, any_acc, ship_hit;
    logic       wr_ctrl, wr_clear, wr_hitclr;
    logic [5:0] eb_field;
    logic [4:0] b_field;
    logic [7:0] rd_mux;
    logic       unused_wdata;

    assign frame_end    = (vcount_q == 10'd479) && (vcount == 10'd480);
    assign sample       = pixel_valid && enable;
    assign wr_ctrl      = chipselect && write && (address == REG_CTRL);
    assign wr_clear     = chipselect && write && (address == REG_CLEAR);
    assign wr_hitclr    = chipselect && write && (address == REG_HITCLR);
    assign irq          = irq_pending && irq_en;
    assign unused_wdata = ^writedata[7:2];

    // Accumulators including this cycle's overlaps, so a frame_end sample is not lost
    always_comb begin
        nxt_se = acc_se;
        nxt_eb = acc_eb;
        nxt_b  = acc_b;
        nxt_e  = acc_e;
        if (sample) begin
            nxt_se = acc_se | (ship_on & (|enemy_on));
            nxt_eb = acc_eb | ({MAX_ENEMY_BULLETS{ship_on}} & enemy_bullet_on);
            nxt_b  = acc_b  | (bullet_on & {MAX_BULLETS{|enemy_on}});
            nxt_e  = acc_e  | (enemy_on & {2{|bullet_on}});
        end
        ship_hit = nxt_se | (|nxt_eb);
        any_acc  = ship_hit | (|nxt_b) | (|nxt_e);
    end

    always_comb begin
        eb_field = '0;
        b_field  = '0;
        eb_field[EB_W-1:0] = stat_eb[EB_W-1:0];
        b_field[B_W-1:0]   = stat_b[B_W-1:0];
        case (address)
            REG_STAT0:  rd_mux = {1'b0, stat_se, eb_field};
            REG_STAT1:  rd_mux = {1'b0, stat_e, b_field};
            REG_FRAMES: rd_mux = frame_count;
            REG_HITS:   rd_mux = ship_hits;
            REG_CTRL:   rd_mux = {6'b0, enable, irq_en};
            REG_CLEAR:  rd_mux = {7'b0, irq_pending};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vcount_q    <= '0;
            acc_se      <= 1'b0;
            acc_eb      <= '0;
            acc_b       <= '0;
            acc_e       <= '0;
            stat_se     <= 1'b0;
            stat_eb     <= '0;
            stat_b      <= '0;
            stat_e      <= '0;
            frame_count <= '0;
            ship_hits   <= '0;
            irq_pending <= 1'b0;
            irq_en      <= 1'b0;
            enable      <= 1'b1;
            readdata    <= '0;
        end else begin
            vcount_q <= vcount;
            if (chipselect && read)
                readdata <= rd_mux;

            // A CLEAR on the frame_end cycle wipes old status before the new frame lands
            if (frame_end) begin
                acc_se      <= 1'b0;
                acc_eb      <= '0;
                acc_b       <= '0;
                acc_e       <= '0;
                stat_se     <= (wr_clear ? 1'b0 : stat_se) | nxt_se;
                stat_eb     <= (wr_clear ? '0 : stat_eb) | nxt_eb;
                stat_b      <= (wr_clear ? '0 : stat_b) | nxt_b;
                stat_e      <= (wr_clear ? '0 : stat_e) | nxt_e;
                irq_pending <= (wr_clear ? 1'b0 : irq_pending) | any_acc;
                frame_count <= frame_count + 8'd1;
            end else begin
                acc_se <= nxt_se;
                acc_eb <= nxt_eb;
                acc_b  <= nxt_b;
                acc_e  <= nxt_e;
                if (wr_clear) begin
                    stat_se     <= 1'b0;
                    stat_eb     <= '0;
                    stat_b      <= '0;
                    stat_e      <= '0;
                    irq_pending <= 1'b0;
                end
            end

            if (frame_end && ship_hit)
                ship_hits <= wr_hitclr ? 8'd1 :
                             (ship_hits == 8'hFF) ? ship_hits : ship_hits + 8'd1;
            else if (wr_hitclr)
                ship_hits <= '0;

            if (wr_ctrl) begin
                irq_en <= writedata[0];
                enable <= writedata[1];
            end
        end
    end

endmodule

// File: tb/tb_vga_collision.sv
// Randomized and directed bench for vga_collision against a frame-level reference model.
module tb_vga_collision;

    localparam int NB  = 5;
    localparam int NEB = 6;

    logic           clk = 1'b0;
    logic           reset, pixel_valid, ship_on, chipselect, read, write, irq;
    logic [9:0]     vcount;
    logic [1:0]     enemy_on;
    logic [NB-1:0]  bullet_on;
    logic [NEB-1:0] enemy_bullet_on;
    logic [2:0]     address;
    logic [7:0]     writedata, readdata;

    always #5 clk = ~clk;

    vga_collision #(.MAX_BULLETS(NB), .MAX_ENEMY_BULLETS(NEB)) dut (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .vcount(vcount),
        .ship_on(ship_on), .enemy_on(enemy_on), .bullet_on(bullet_on),
        .enemy_bullet_on(enemy_bullet_on), .chipselect(chipselect), .read(read),
        .write(write), .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what has been seen this frame, and what was published
    bit m_se_acc, m_se_st;
    bit m_eb_acc[NEB], m_eb_st[NEB];
    bit m_b_acc[NB], m_b_st[NB];
    bit m_e_acc[2], m_e_st[2];
    int m_frames, m_hits, m_vq;
    bit m_irqp, m_irqen, m_en;
    logic [7:0] m_rd;

    function automatic logic [7:0] m_reg(input logic [2:0] a);
        logic [7:0] v;
        v = '0;
        case (a)
            3'd0: begin
                for (int j = 0; j < NEB; j++) v[j] = m_eb_st[j];
                v[6] = m_se_st;
            end
            3'd1: begin
                for (int i = 0; i < NB; i++) v[i] = m_b_st[i];
                v[5] = m_e_st[0];
                v[6] = m_e_st[1];
            end
            3'd2: v = 8'(m_frames);
            3'd3: v = 8'(m_hits);
            3'd4: v = {6'b0, m_en, m_irqen};
            3'd5: v = {7'b0, m_irqp};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_se_acc = 0; m_se_st = 0;
        for (int j = 0; j < NEB; j++) begin m_eb_acc[j] = 0; m_eb_st[j] = 0; end
        for (int i = 0; i < NB; i++) begin m_b_acc[i] = 0; m_b_st[i] = 0; end
        for (int k = 0; k < 2; k++) begin m_e_acc[k] = 0; m_e_st[k] = 0; end
        m_frames = 0; m_hits = 0; m_vq = 0;
        m_irqp = 0; m_irqen = 0; m_en = 1; m_rd = '0;
    endtask

    task automatic model_edge();
        bit fe, any_enemy, any_bullet, clr, hclr, ship_hit, any_hit;
        if (reset) begin
            model_reset();
            return;
        end
        fe         = (m_vq == 479) && (vcount == 10'd480);
        any_enemy  = (enemy_on != 0);
        any_bullet = (bullet_on != 0);
        clr        = chipselect && write && (address == 3'd5);
        hclr       = chipselect && write && (address == 3'd6);
        if (chipselect && read) m_rd = m_reg(address);
        if (pixel_valid && m_en) begin
            if (ship_on && any_enemy) m_se_acc = 1;
            for (int j = 0; j < NEB; j++) if (ship_on && enemy_bullet_on[j]) m_eb_acc[j] = 1;
            for (int i = 0; i < NB; i++) if (bullet_on[i] && any_enemy) m_b_acc[i] = 1;
            for (int k = 0; k < 2; k++) if (enemy_on[k] && any_bullet) m_e_acc[k] = 1;
        end
        ship_hit = m_se_acc;
        for (int j = 0; j < NEB; j++) ship_hit |= m_eb_acc[j];
        any_hit = ship_hit;
        for (int i = 0; i < NB; i++) any_hit |= m_b_acc[i];
        for (int k = 0; k < 2; k++) any_hit |= m_e_acc[k];
        if (clr) begin
            m_se_st = 0; m_irqp = 0;
            for (int j = 0; j < NEB; j++) m_eb_st[j] = 0;
            for (int i = 0; i < NB; i++) m_b_st[i] = 0;
            for (int k = 0; k < 2; k++) m_e_st[k] = 0;
        end
        if (hclr) m_hits = 0;
        if (fe) begin
            m_se_st |= m_se_acc; m_se_acc = 0;
            for (int j = 0; j < NEB; j++) begin m_eb_st[j] |= m_eb_acc[j]; m_eb_acc[j] = 0; end
            for (int i = 0; i < NB; i++) begin m_b_st[i] |= m_b_acc[i]; m_b_acc[i] = 0; end
            for (int k = 0; k < 2; k++) begin m_e_st[k] |= m_e_acc[k]; m_e_acc[k] = 0; end
            if (any_hit) m_irqp = 1;
            if (ship_hit && m_hits < 255) m_hits++;
            m_frames = (m_frames + 1) % 256;
        end
        if (chipselect && write && address == 3'd4) begin
            m_irqen = writedata[0];
            m_en    = writedata[1];
        end
        m_vq = int'(vcount);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("irq", {7'b0, irq}, {7'b0, m_irqp & m_irqen});
        check_eq("readdata", readdata, m_rd);
    endtask

    task automatic set_px(input logic v, input logic s, input logic [1:0] e,
                          input logic [NB-1:0] b, input logic [NEB-1:0] eb);
        vcount = 10'd100; pixel_valid = v; ship_on = s;
        enemy_on = e; bullet_on = b; enemy_bullet_on = eb;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        tick();
        chipselect = 0; write = 0;
    endtask

    task automatic bus_read(input logic [2:0] a, input string tag, input logic [7:0] exp);
        chipselect = 1; read = 1; address = a;
        tick();
        chipselect = 0; read = 0;
        check_eq(tag, readdata, exp);
    endtask

    task automatic end_frame_op(input logic do_wr, input logic [2:0] a, input logic [7:0] d);
        set_px(0, 0, 2'b0, '0, '0);
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        if (do_wr) begin chipselect = 1; write = 1; address = a; writedata = d; end
        tick();
        chipselect = 0; write = 0; vcount = 10'd0;
    endtask

    task automatic pulse_reset();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        int len, r;
        logic [2:0] ra;
        model_reset();
        reset = 1; chipselect = 0; read = 0; write = 0; address = '0; writedata = '0;
        set_px(0, 0, 2'b0, '0, '0);
        tick(); tick();
        reset = 0;
        for (int a = 0; a < 8; a++) bus_read(3'(a), "reset_reg", (a == 4) ? 8'h02 : 8'h00);

        // ship vs enemy bullet 2 for three cycles
        set_px(1, 1, 2'b00, '0, 6'b000100);
        repeat (3) tick();
        end_frame_op(0, 0, 0);
        check_eq("irq_disabled", {7'b0, irq}, 8'h00);
        bus_read(3'd0, "stat0_eb2", 8'h04);
        bus_read(3'd3, "hits_one", 8'h01);
        bus_read(3'd2, "frames_one", 8'h01);

        // bullet 1 vs enemy 1 with irq enabled, then CLEAR
        bus_write(3'd5, 8'h00);
        bus_write(3'd4, 8'h03);
        set_px(1, 0, 2'b10, 5'b00010, '0);
        tick();
        end_frame_op(0, 0, 0);
        check_eq("irq_raised", {7'b0, irq}, 8'h01);
        bus_read(3'd1, "stat1_hit", 8'h42);
        bus_write(3'd5, 8'hAA);
        check_eq("irq_cleared", {7'b0, irq}, 8'h00);
        bus_read(3'd1, "stat1_cleared", 8'h00);

        // overlaps masked by pixel_valid=0, then by enable=0
        set_px(0, 1, 2'b11, '1, '1);
        repeat (4) tick();
        end_frame_op(0, 0, 0);
        bus_read(3'd0, "stat0_blank", 8'h00);
        bus_read(3'd1, "stat1_blank", 8'h00);
        bus_read(3'd2, "frames_blank", 8'h03);
        bus_write(3'd4, 8'h00);
        set_px(1, 1, 2'b11, '1, '1);
        repeat (4) tick();
        end_frame_op(0, 0, 0);
        bus_read(3'd0, "stat0_disabled", 8'h00);
        bus_read(3'd1, "stat1_disabled", 8'h00);
        bus_read(3'd2, "frames_disabled", 8'h04);
        bus_write(3'd4, 8'h03);

        // disable mid-frame keeps what was already gathered
        set_px(1, 1, 2'b01, '0, '0);
        tick();
        set_px(0, 0, 2'b00, '0, '0);
        bus_write(3'd4, 8'h01);
        set_px(1, 1, 2'b00, '0, 6'b000001);
        tick();
        end_frame_op(0, 0, 0);
        bus_read(3'd0, "stat0_middisable", 8'h40);
        bus_read(3'd3, "hits_two", 8'h02);
        bus_write(3'd4, 8'h03);
        bus_write(3'd5, 8'h00);

        // CLEAR coinciding with frame_end of a hit frame
        set_px(1, 1, 2'b00, '0, 6'b000001);
        tick();
        end_frame_op(0, 0, 0);
        bus_read(3'd0, "stat0_frameA", 8'h01);
        set_px(1, 1, 2'b00, '0, 6'b001000);
        tick();
        end_frame_op(1, 3'd5, 8'h00);
        bus_read(3'd0, "stat0_clear_fe", 8'h08);
        bus_read(3'd5, "irqp_clear_fe", 8'h01);

        // HITCLR coinciding with frame_end, with and without a ship hit
        set_px(1, 1, 2'b01, '0, '0);
        tick();
        end_frame_op(1, 3'd6, 8'h00);
        bus_read(3'd3, "hits_hitclr_fe", 8'h01);
        end_frame_op(1, 3'd6, 8'h00);
        bus_read(3'd3, "hits_hitclr_nohit", 8'h00);

        // frame counter wrap and hit counter saturation
        pulse_reset();
        repeat (256) end_frame_op(0, 0, 0);
        bus_read(3'd2, "frames_wrap", 8'h00);
        repeat (300) begin
            set_px(1, 1, 2'b01, '0, '0);
            tick();
            end_frame_op(0, 0, 0);
        end
        bus_read(3'd3, "hits_saturate", 8'hFF);
        bus_read(3'd2, "frames_300", 8'd44);

        // reset mid-frame discards partial accumulation
        set_px(1, 1, 2'b11, '1, '1);
        tick();
        set_px(0, 0, 2'b00, '0, '0);
        pulse_reset();
        end_frame_op(0, 0, 0);
        bus_read(3'd0, "stat0_after_reset", 8'h00);
        bus_read(3'd1, "stat1_after_reset", 8'h00);
        bus_read(3'd2, "frames_after_reset", 8'h01);

        // randomized frames with random bus traffic
        for (int f = 0; f < 80; f++) begin
            len = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                vcount          = 10'($urandom_range(0, 478));
                pixel_valid     = ($urandom_range(0, 3) != 0);
                ship_on         = ($urandom_range(0, 2) == 0);
                enemy_on        = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
                bullet_on       = NB'($urandom) & NB'($urandom) & NB'($urandom);
                enemy_bullet_on = NEB'($urandom) & NEB'($urandom) & NEB'($urandom);
                r               = $urandom_range(0, 7);
                chipselect      = (r < 3);
                read            = (r < 2);
                write           = (r == 2);
                address         = 3'($urandom_range(0, 7));
                writedata       = 8'($urandom);
                reset           = ($urandom_range(0, 299) == 0);
                tick();
            end
            reset = 0; chipselect = 0; read = 0; write = 0;
            r = $urandom_range(0, 3);
            end_frame_op(r == 0, 3'($urandom_range(4, 6)), 8'($urandom) | 8'h02);
            ra = 3'($urandom_range(0, 7));
            bus_read(ra, "rand_reg", m_reg(ra));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
